// File: rtl/wbarb_router.sv
// rtl/wbarb_router.sv - round-robin multi-master Wishbone classic-cycle router
//
// Purpose:
//   NM classic-cycle Wishbone masters share NS slaves. One master is granted
//   at a time by a round-robin arbiter. The granted master's top MUXWIDTH
//   address bits are decoded every cycle against SLAVE_MUX, and the lowest
//   matching slot is the selected slave. Unmapped addresses get a registered
//   one-cycle error pulse.
//
// Optional feature macro: WBARB_ROUTER_TIMEOUT_EN
//   When defined, a wait counter returns an error to the granted master if
//   the selected slave stalls for MAX_WAIT strobed cycles.
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_mcyc/i_mstb/i_mwe            per-master cycle, strobe, write enable
//   i_maddr/i_mdata/i_msel         per-master address, write data, byte selects
//   o_mack/o_merr/o_mdata          per-master ack, error, read data
//   o_grant                        one-hot current grant (status)
//   o_scyc/o_sstb/o_swe            per-slave cycle, strobe, write enable
//   o_saddr/o_sdata/o_ssel         per-slave address (low SAW bits), data, selects
//   i_sack/i_serr/i_sdata          per-slave ack, error, read data

module wbarb_router #(
  parameter int NM = 2,
  parameter int NS = 4,
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int MUXWIDTH = 4,
  parameter logic [NS*MUXWIDTH-1:0] SLAVE_MUX = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int MAX_WAIT = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NM-1:0]                 i_mcyc,
  input  logic [NM-1:0]                 i_mstb,
  input  logic [NM-1:0]                 i_mwe,
  input  logic [NM*AW-1:0]              i_maddr,
  input  logic [NM*DW-1:0]              i_mdata,
  input  logic [NM*DW/8-1:0]            i_msel,
  output logic [NM-1:0]                 o_mack,
  output logic [NM-1:0]                 o_merr,
  output logic [NM*DW-1:0]              o_mdata,
  output logic [NM-1:0]                 o_grant,
  output logic [NS-1:0]                 o_scyc,
  output logic [NS-1:0]                 o_sstb,
  output logic [NS-1:0]                 o_swe,
  output logic [NS*(AW-MUXWIDTH)-1:0]   o_saddr,
  output logic [NS*DW-1:0]              o_sdata,
  output logic [NS*DW/8-1:0]            o_ssel,
  input  logic [NS-1:0]                 i_sack,
  input  logic [NS-1:0]                 i_serr,
  input  logic [NS*DW-1:0]              i_sdata
);

  localparam int SAW = AW - MUXWIDTH;
  localparam int SW  = DW / 8;
  localparam int GW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int SIW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [NM-1:0]   r_grant;
  logic [GW-1:0]   r_gidx;
  logic [GW-1:0]   r_ptr;
  logic            r_derr;

  logic [NM-1:0]   w_req;
  logic [GW-1:0]   w_pick;
  logic            w_found;
  logic            w_active;

  logic            w_mcyc;
  logic            w_mstb;
  logic            w_mwe;
  logic [AW-1:0]   w_maddr;
  logic [DW-1:0]   w_mdata;
  logic [SW-1:0]   w_msel;

  logic            w_hit;
  logic [SIW-1:0]  w_sidx;
  logic            w_ack;
  logic            w_err;
  logic            w_tmo;
  logic            w_tblk;

  assign w_active = (r_state == S_ACTIVE);

  // Granted master's signals
  assign w_mcyc  = i_mcyc[r_gidx];
  assign w_mstb  = i_mstb[r_gidx];
  assign w_mwe   = i_mwe[r_gidx];
  assign w_maddr = i_maddr[r_gidx*AW +: AW];
  assign w_mdata = i_mdata[r_gidx*DW +: DW];
  assign w_msel  = i_msel[r_gidx*SW +: SW];

  // Round-robin: first requester strictly after the last granted master
  always_comb begin
    w_req   = i_mcyc & i_mstb;
    w_pick  = r_ptr;
    w_found = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      if (!w_found && w_req[(int'(r_ptr) + i) % NM]) begin
        w_found = 1'b1;
        w_pick  = GW'((int'(r_ptr) + i) % NM);
      end
    end
  end

  // Address decode; scanning downward leaves the lowest matching slot
  always_comb begin
    w_hit  = 1'b0;
    w_sidx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (w_maddr[AW-1 -: MUXWIDTH] == SLAVE_MUX[k*MUXWIDTH +: MUXWIDTH]) begin
        w_hit  = 1'b1;
        w_sidx = SIW'(k);
      end
    end
  end

  // Forwarded slave response; suppressed while a timed-out access is blocked
  assign w_ack = w_hit & i_sack[w_sidx] & w_mstb & ~w_tblk & ~w_tmo;
  assign w_err = w_hit & i_serr[w_sidx] & w_mstb & ~w_tblk & ~w_tmo;

`ifdef WBARB_ROUTER_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_wait;
  logic          r_tblk;

  assign w_tmo  = w_active & w_hit & (r_wait == CW'(MAX_WAIT));
  assign w_tblk = r_tblk;

  // r_tblk ignores late acks from a timed-out slave until stb drops
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait <= '0;
      r_tblk <= 1'b0;
    end else if (!w_active) begin
      r_wait <= '0;
      r_tblk <= 1'b0;
    end else if (w_tmo) begin
      r_wait <= '0;
      r_tblk <= 1'b1;
    end else if (r_tblk) begin
      if (!w_mstb) r_tblk <= 1'b0;
    end else if (w_mstb && (w_ack || w_err)) begin
      r_wait <= '0;
    end else if (w_mstb && w_hit) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  assign w_tmo  = 1'b0;
  assign w_tblk = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_mack  = '0;
    o_merr  = '0;
    o_mdata = '0;
    o_grant = '0;
    o_scyc  = '0;
    o_sstb  = '0;
    o_swe   = '0;
    o_saddr = '0;
    o_sdata = '0;
    o_ssel  = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) w_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!w_mcyc) w_next = S_IDLE;
        o_grant = r_grant;
        o_swe   = {NS{w_mwe}};
        o_saddr = {NS{w_maddr[SAW-1:0]}};
        o_sdata = {NS{w_mdata}};
        o_ssel  = {NS{w_msel}};
        if (w_hit) begin
          if (!w_tmo) begin
            o_scyc[w_sidx] = w_mcyc;
            o_sstb[w_sidx] = w_mstb;
          end
          o_mdata        = {NM{i_sdata[w_sidx*DW +: DW]}};
          o_mack[r_gidx] = w_ack;
          o_merr[r_gidx] = w_err | w_tmo;
        end else begin
          o_merr[r_gidx] = r_derr;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Grant bookkeeping and the decode-error pulse. r_derr self-clears so it
  // can fire at most every other cycle while stb is held on a bad address.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= GW'(NM - 1);
      r_derr  <= 1'b0;
    end else if (!w_active) begin
      r_derr <= 1'b0;
      if (w_found) begin
        r_grant <= NM'(1) << w_pick;
        r_gidx  <= w_pick;
        r_ptr   <= w_pick;
      end
    end else begin
      r_derr <= w_mcyc & w_mstb & ~w_hit & ~r_derr;
      if (!w_mcyc) r_grant <= '0;
    end
  end

endmodule

// File: tb/tb_wbarb_router.sv
// tb/tb_wbarb_router.sv - directed self-checking bench for wbarb_router

module tb_wbarb_router;

  logic        i_clk;
  logic        i_reset;
  logic [1:0]  i_mcyc, i_mstb, i_mwe;
  logic [31:0] i_maddr, i_mdata;
  logic [3:0]  i_msel;
  logic [1:0]  o_mack, o_merr, o_grant;
  logic [31:0] o_mdata;
  logic [3:0]  o_scyc, o_sstb, o_swe;
  logic [47:0] o_saddr;
  logic [63:0] o_sdata;
  logic [7:0]  o_ssel;
  logic [3:0]  i_sack, i_serr;
  logic [63:0] i_sdata;

  int n_checks = 0;
  int n_errors = 0;

  wbarb_router dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
    .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
    .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata), .o_grant(o_grant),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge i_clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        stb;
    logic [3:0]  sack;
    logic [3:0]  serr;
    logic [3:0]  exp_cyc;
    logic [3:0]  exp_stb;
    logic [1:0]  exp_ack;
    logic [1:0]  exp_err;
    logic [15:0] exp_rd;
    logic [11:0] exp_saddr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ng;
    bit idle_seen;
    bit dropped0, dropped1;
    bit any_err;
    logic [1:0] exp_order[4];

    vecs[0] = '{16'h3000, 1'b1, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 2'b00, 2'b00, 16'hD333, 12'h000};
    vecs[1] = '{16'h3abc, 1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 2'b01, 2'b00, 16'hD333, 12'habc};
    vecs[2] = '{16'h1234, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'b01, 2'b00, 16'hB111, 12'h234};
    vecs[3] = '{16'h1234, 1'b1, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 2'b00, 2'b00, 16'hB111, 12'h234};
    vecs[4] = '{16'h2fff, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'b00, 2'b00, 16'hC222, 12'hfff};
    vecs[5] = '{16'h0001, 1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 2'b00, 2'b01, 16'hA000, 12'h001};
    vecs[6] = '{16'h0001, 1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 2'b01, 2'b01, 16'hA000, 12'h001};
    vecs[7] = '{16'h2000, 1'b1, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 2'b00, 2'b01, 16'hC222, 12'h000};
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;

    i_reset = 1'b1;
    i_mcyc = '0; i_mstb = '0; i_mwe = '0;
    i_maddr = '0; i_mdata = '0; i_msel = '0;
    i_sack = '0; i_serr = '0; i_sdata = '0;

    // Reset state
    sample();
    sample();
    check("rst_grant", o_grant, 2'b00);
    check("rst_scyc", o_scyc, 4'b0000);
    check("rst_mack_merr", {o_mack, o_merr}, 4'b0000);
    check("rst_mdata", o_mdata, 32'h0);
    i_reset = 1'b0;

    // Master 0 writes 16'h2211 to 16'h3000, slave 3 acks one cycle later
    sample();
    i_mcyc = 2'b01; i_mstb = 2'b01; i_mwe = 2'b01;
    i_maddr[15:0] = 16'h3000; i_mdata[15:0] = 16'h2211; i_msel[1:0] = 2'b11;
    #1;
    check("wr_arb_latency_sstb", o_sstb, 4'b0000);
    sample();
    check("wr_grant", o_grant, 2'b01);
    check("wr_scyc", o_scyc, 4'b1000);
    check("wr_sstb", o_sstb, 4'b1000);
    check("wr_saddr3", o_saddr[47:36], 12'h000);
    check("wr_sdata3", o_sdata[63:48], 16'h2211);
    check("wr_swe_ssel3", {o_swe[3], o_ssel[7:6]}, 3'b111);
    check("wr_no_ack_yet", o_mack, 2'b00);
    sample();
    i_sack = 4'b1000;
    #1;
    check("wr_ack", o_mack, 2'b01);
    i_mcyc = 2'b00; i_mstb = 2'b00; i_mwe = 2'b00; i_sack = 4'b0000;
    sample();
    check("wr_ack_single", o_mack, 2'b00);
    check("wr_idle_grant", o_grant, 2'b00);

    // Master 1 reads 16'h1004, slave 1 returns 16'h1111
    i_mcyc = 2'b10; i_mstb = 2'b10; i_maddr[31:16] = 16'h1004;
    i_sdata = {16'h0, 16'h0, 16'h1111, 16'h0};
    sample();
    check("rd_grant", o_grant, 2'b10);
    check("rd_sstb", o_sstb, 4'b0010);
    check("rd_saddr1", o_saddr[23:12], 12'h004);
    sample();
    i_sack = 4'b0010;
    #1;
    check("rd_ack", o_mack, 2'b10);
    check("rd_mdata", o_mdata, {16'h1111, 16'h1111});
    i_mcyc = 2'b00; i_mstb = 2'b00; i_sack = 4'b0000;
    sample();

    // Both masters request repeatedly; each drops cyc for one cycle after its ack
    i_maddr = {16'h3000, 16'h3000};
    i_sack = 4'b1000;
    i_mcyc = 2'b11; i_mstb = 2'b11;
    ng = 0; idle_seen = 1'b1; dropped0 = 1'b0; dropped1 = 1'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      sample();
      if (o_grant == 2'b00) idle_seen = 1'b1;
      if (o_mack != 2'b00) begin
        check($sformatf("rr_grant%0d", ng), o_grant, exp_order[ng]);
        if (ng > 0) check($sformatf("rr_idle_gap%0d", ng), idle_seen, 1'b1);
        idle_seen = 1'b0;
        ng++;
      end
      if (dropped0) begin i_mcyc[0] = 1'b1; i_mstb[0] = 1'b1; dropped0 = 1'b0; end
      if (dropped1) begin i_mcyc[1] = 1'b1; i_mstb[1] = 1'b1; dropped1 = 1'b0; end
      if (o_mack[0]) begin i_mcyc[0] = 1'b0; i_mstb[0] = 1'b0; dropped0 = 1'b1; end
      if (o_mack[1]) begin i_mcyc[1] = 1'b0; i_mstb[1] = 1'b0; dropped1 = 1'b1; end
    end
    check("rr_grant_count", ng, 4);
    i_mcyc = 2'b00; i_mstb = 2'b00; i_sack = 4'b0000;
    sample();
    sample();

    // Table: master 0 granted, master 1 requesting and stalled
    i_sdata = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
    i_maddr = {16'h3000, 16'h3000};
    i_mcyc = 2'b11; i_mstb = 2'b11; i_mwe = 2'b00;
    sample();
    check("tbl_grant", o_grant, 2'b01);
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      i_maddr[15:0] = vecs[i].addr;
      i_mstb[0] = vecs[i].stb;
      i_sack = vecs[i].sack;
      i_serr = vecs[i].serr;
      #1;
      check($sformatf("vec%0d_scyc", i), o_scyc, vecs[i].exp_cyc);
      check($sformatf("vec%0d_sstb", i), o_sstb, vecs[i].exp_stb);
      check($sformatf("vec%0d_mack", i), o_mack, vecs[i].exp_ack);
      check($sformatf("vec%0d_merr", i), o_merr, vecs[i].exp_err);
      check($sformatf("vec%0d_rdata", i), o_mdata[15:0], vecs[i].exp_rd);
      check($sformatf("vec%0d_saddr", i), o_saddr[11:0], vecs[i].exp_saddr);
    end
    i_mcyc = 2'b00; i_mstb = 2'b00; i_sack = 4'b0000; i_serr = 4'b0000;
    sample();
    sample();

    // Unmapped address: registered error two cycles after the request
    i_maddr[15:0] = 16'h8000;
    i_mcyc = 2'b01; i_mstb = 2'b01;
    #1;
    check("dec_req_merr", o_merr, 2'b00);
    sample();
    check("dec_c1_scyc", o_scyc, 4'b0000);
    check("dec_c1_merr", o_merr, 2'b00);
    sample();
    check("dec_c2_merr", o_merr, 2'b01);
    check("dec_c2_mack", o_mack, 2'b00);
    check("dec_c2_scyc", o_scyc, 4'b0000);
    sample();
    check("dec_c3_no_refire", o_merr, 2'b00);
    i_mcyc = 2'b00; i_mstb = 2'b00;
    sample();
    sample();

    // Slave 2 never acks
    i_maddr[15:0] = 16'h2000;
    i_mcyc = 2'b01; i_mstb = 2'b01;
    any_err = 1'b0;
`ifdef WBARB_ROUTER_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      sample();
      if (c < 9 && o_merr != 2'b00) any_err = 1'b1;
      if (c == 9) begin
        check("tmo_merr_pulse", o_merr, 2'b01);
        check("tmo_sstb_drop", o_sstb, 4'b0000);
      end
    end
    check("tmo_no_early_err", any_err, 1'b0);
    sample();
    check("tmo_pulse_end", o_merr, 2'b00);
`else
    for (int c = 1; c <= 50; c++) begin
      sample();
      if (o_merr != 2'b00) any_err = 1'b1;
    end
    check("stall_no_err", any_err, 1'b0);
    check("stall_sstb", o_sstb, 4'b0100);
`endif

    // Asynchronous reset in the middle of the stalled access
    #2;
    i_reset = 1'b1;
    #1;
    check("arst_grant", o_grant, 2'b00);
    check("arst_slave", {o_scyc, o_sstb, o_swe}, 12'h000);
    check("arst_master", {o_mack, o_merr}, 4'b0000);
    check("arst_bus", {o_saddr, o_mdata}, 80'h0);
    i_maddr = {16'h3000, 16'h3000};
    i_mcyc = 2'b11; i_mstb = 2'b11;
    sample();
    check("arst_hold_grant", o_grant, 2'b00);
    i_reset = 1'b0;
    sample();
    check("arst_first_grant", o_grant, 2'b01);
    i_mcyc = 2'b00; i_mstb = 2'b00;
    sample();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
